booth_mac_pe: RTL and testbench

//  Systolic-array processing element. Consumes the 16-bit signed product of radix_8_booth_sel_mul
//   and accumulates K_LEN products into one dot-product result.

---
 rtl/pe_pkg.sv | 16 +
 rtl/radix_8_booth_sel_mul.sv | 50 +++++
 rtl/booth_mac_pe.sv | 119 +++++++++++
 tb/tb_booth_mac_pe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared widths, FSM state type and sign-extension helper for the booth_mac_pe slice.
package pe_pkg;

   localparam int DATA_W = 8;
   localparam int PROD_W = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } pe_state_e;

   function automatic logic signed [63:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return {{(64-PROD_W){p[PROD_W-1]}}, p};
   endfunction

endpackage

// File: rtl/radix_8_booth_sel_mul.sv
// Combinational 8x8 signed multiplier using radix-8 Booth recoding (digits -4..+4)
// with one-hot style multiple selection per digit.
module radix_8_booth_sel_mul
   import pe_pkg::*;
(
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [PROD_W-1:0] p
);

   localparam int N_DIG = 3;

   logic [9:0]               b_pad;
   logic signed [PROD_W-1:0] a1, a2, a3, a4;
   logic signed [PROD_W-1:0] pp [N_DIG];

   // b sign-extended to 9 bits plus an implicit 0 below the LSB gives three overlapping windows
   assign b_pad = {b[DATA_W-1], b, 1'b0};
   assign a1    = PROD_W'(a);
   assign a2    = a1 <<< 1;
   assign a3    = a1 + a2;
   assign a4    = a1 <<< 2;

   genvar gi;
   generate
      for (gi = 0; gi < N_DIG; gi++) begin : g_dig
         logic [3:0]               win;
         logic signed [PROD_W-1:0] mag;

         assign win = b_pad[3*gi +: 4];

         always_comb begin
            mag = '0;
            case (win)
               4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = a1;
               4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = a2;
               4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = a3;
               4'b0111, 4'b1000:                   mag = a4;
               default:                            mag = '0;
            endcase
         end

         // The window MSB carries weight -4, so it alone decides the digit sign
         assign pp[gi] = (win[3] ? -mag : mag) <<< (3*gi);
      end
   endgenerate

   assign p = pp[0] + pp[1] + pp[2];

endmodule

// File: rtl/booth_mac_pe.sv
// booth_mac_pe: systolic PE forwarding a/b east/south and accumulating K_LEN Booth products.
// Optional build macro ZERO_GATE_EN suppresses multiplier toggling on zero operands.
module booth_mac_pe
   import pe_pkg::*;
#(
   parameter int K_LEN = 4,
   parameter int ACC_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_vld,
   input  logic signed [DATA_W-1:0] a_in,
   input  logic signed [DATA_W-1:0] b_in,
   input  logic                     flush,
   output logic signed [DATA_W-1:0] a_out,
   output logic signed [DATA_W-1:0] b_out,
   output logic                     vld_out,
   output logic signed [ACC_W-1:0]  res,
   output logic                     res_vld,
   output logic                     skip_o
);

   localparam int              CNT_W    = (K_LEN > 1) ? $clog2(K_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);

   logic signed [DATA_W-1:0] mul_a_reg, mul_b_reg;
   logic signed [PROD_W-1:0] prod, p_q_reg, p_q_next;
   logic                     v2_reg;
   logic                     load_mul;
   logic [CNT_W-1:0]         cnt_reg;
   logic signed [ACC_W-1:0]  acc_reg, sp, sum_next;
   pe_state_e                state_reg;

`ifdef ZERO_GATE_EN
   logic zero_in, zero_reg;

   assign zero_in  = (a_in == '0) || (b_in == '0);
   assign load_mul = in_vld && !flush && !zero_in;
   assign skip_o   = zero_reg;
   // The held multiplier operands are stale, so the product is forced to zero instead
   assign p_q_next = zero_reg ? '0 : prod;

   always_ff @(posedge clk) begin
      if (rst) zero_reg <= 1'b0;
      else     zero_reg <= in_vld && !flush && zero_in;
   end
`else
   assign load_mul = in_vld && !flush;
   assign skip_o   = 1'b0;
   assign p_q_next = prod;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         a_out     <= '0;
         b_out     <= '0;
         vld_out   <= 1'b0;
         mul_a_reg <= '0;
         mul_b_reg <= '0;
      end else begin
         a_out   <= a_in;
         b_out   <= b_in;
         vld_out <= in_vld && !flush;
         if (load_mul) begin
            mul_a_reg <= a_in;
            mul_b_reg <= b_in;
         end
      end
   end

   radix_8_booth_sel_mul u_mul (
      .a (mul_a_reg),
      .b (mul_b_reg),
      .p (prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q_reg <= '0;
         v2_reg  <= 1'b0;
      end else begin
         p_q_reg <= p_q_next;
         v2_reg  <= vld_out && !flush;
      end
   end

   assign sp       = ACC_W'(sext_prod(p_q_reg));
   // IDLE marks the first product of a group, which replaces rather than adds
   assign sum_next = ((state_reg == IDLE) ? '0 : acc_reg) + sp;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg   <= '0;
         cnt_reg   <= '0;
         state_reg <= IDLE;
         res       <= '0;
         res_vld   <= 1'b0;
      end else begin
         res_vld <= 1'b0;
         if (flush) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= IDLE;
         end else if (v2_reg) begin
            acc_reg <= sum_next;
            if (cnt_reg == CNT_LAST) begin
               res       <= sum_next;
               res_vld   <= 1'b1;
               cnt_reg   <= '0;
               state_reg <= IDLE;
            end else begin
               cnt_reg   <= cnt_reg + 1'b1;
               state_reg <= ACCUM;
            end
         end
      end
   end

endmodule

// File: tb/tb_booth_mac_pe.sv
// Self-checking bench for booth_mac_pe: directed dot products pinned to literals, then random
// traffic with flush/reset, all checked every cycle against an input-level behavioural model.
module tb_booth_mac_pe;

   localparam int K_LEN = 4;
   localparam int ACC_W = 32;
`ifdef ZERO_GATE_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst, in_vld, flush;
   logic [7:0]              a_in, b_in, a_out, b_out;
   logic                    vld_out, res_vld, skip_o;
   logic signed [ACC_W-1:0] res;

   booth_mac_pe #(.K_LEN(K_LEN), .ACC_W(ACC_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .a_in    (a_in),
      .b_in    (b_in),
      .flush   (flush),
      .a_out   (a_out),
      .b_out   (b_out),
      .vld_out (vld_out),
      .res     (res),
      .res_vld (res_vld),
      .skip_o  (skip_o)
   );

   always #5 clk = ~clk;

   // model state (written only by the compare process)
   int                      cyc = 0;
   int                      n_tests = 0;
   int                      n_fail = 0;
   bit                      armed = 1'b0;
   bit                      chk_ab;
   logic                    i_rst, i_vld, i_flush;
   logic signed [7:0]       i_a, i_b;
   longint                  grp_sum;
   int                      grp_cnt;
   int                      due_q[$];
   logic signed [ACC_W-1:0] val_q[$];
   logic [7:0]              exp_a, exp_b;
   logic                    exp_vld, exp_res_vld, exp_skip;
   logic signed [ACC_W-1:0] exp_res;
   int                      lit_idx = 0;

   // literal expectations (written only by the stimulus process)
   int lit_cyc[16];
   int lit_val[16];
   int lit_n = 0;
   bit done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, $signed(act), $signed(exp));
      end
   endtask

   always @(posedge clk) begin
      i_rst   = rst;
      i_vld   = in_vld;
      i_flush = flush;
      i_a     = a_in;
      i_b     = b_in;
      if (i_rst) begin
         armed       = 1'b1;
         exp_a       = '0;
         exp_b       = '0;
         exp_vld     = 1'b0;
         exp_skip    = 1'b0;
         exp_res     = '0;
         exp_res_vld = 1'b0;
         grp_sum     = 0;
         grp_cnt     = 0;
         due_q.delete();
         val_q.delete();
      end else begin
         exp_a       = i_a;
         exp_b       = i_b;
         exp_vld     = i_vld && !i_flush;
         exp_skip    = GATE && exp_vld && (i_a == 0 || i_b == 0);
         exp_res_vld = 1'b0;
         if (i_flush) begin
            // everything accepted in the last three cycles and the open group is lost
            grp_sum = 0;
            grp_cnt = 0;
            due_q.delete();
            val_q.delete();
         end else begin
            if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
               exp_res     = val_q.pop_front();
               exp_res_vld = 1'b1;
               void'(due_q.pop_front());
            end
            if (i_vld) begin
               grp_sum += longint'(i_a) * longint'(i_b);
               grp_cnt++;
               if (grp_cnt == K_LEN) begin
                  due_q.push_back(cyc + 3);
                  val_q.push_back(ACC_W'(grp_sum));
                  grp_sum = 0;
                  grp_cnt = 0;
               end
            end
         end
      end
      chk_ab = i_vld || i_rst;
      cyc++;
      #1;
      if (done) begin
         chk("lit_all_seen", lit_idx, lit_n);
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
      if (armed) begin
         if (chk_ab) begin
            chk("a_out", a_out, exp_a);
            chk("b_out", b_out, exp_b);
         end
         chk("vld_out", vld_out, exp_vld);
         chk("res_vld", res_vld, exp_res_vld);
         chk("res", res, exp_res);
         chk("skip_o", skip_o, exp_skip);
         if (lit_idx < lit_n && cyc == lit_cyc[lit_idx]) begin
            chk("lit_res_vld", res_vld, 1);
            chk("lit_res", res, lit_val[lit_idx]);
            chk("lit_model", exp_res, lit_val[lit_idx]);
            lit_idx++;
         end
      end
   end

   task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input bit f, input bit r);
      @(negedge clk);
      in_vld = v;
      a_in   = a;
      b_in   = b;
      flush  = f;
      rst    = r;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic expect_res(input int at, input int val);
      lit_cyc[lit_n] = at;
      lit_val[lit_n] = val;
      lit_n++;
   endtask

   // n contiguous a*b inputs; a result is expected 3 cycles after each K_LEN-th input
   task automatic group(input int n, input logic [7:0] a, input logic [7:0] b, input int val);
      int t0;
      for (int i = 0; i < n; i++) begin
         drive(1'b1, a, b, 1'b0, 1'b0);
         if (i == 0) t0 = cyc;
         if (i % K_LEN == K_LEN - 1) expect_res(t0 + i + 3, val);
      end
   endtask

   int         r;
   logic [7:0] ra, rb;

   initial begin
      rst    = 1'b1;
      in_vld = 1'b0;
      flush  = 1'b0;
      a_in   = '0;
      b_in   = '0;
      for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      idle(2);

      group(4, 8'd3, 8'd5, 60);
      idle(5);
      group(4, 8'h80, 8'h7f, -65024);
      idle(5);
      group(4, 8'h80, 8'h80, 65536);
      idle(5);
      group(8, 8'd2, 8'd2, 16);
      idle(5);

      // aborted group: no result may come out of the two 7x7 inputs
      drive(1'b1, 8'd7, 8'd7, 1'b0, 1'b0);
      drive(1'b1, 8'd7, 8'd7, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      group(4, 8'd1, 8'd1, 4);
      idle(5);

      // zero operand first, then three 1x1
      drive(1'b1, 8'd0, 8'd9, 1'b0, 1'b0);
      expect_res(cyc + 6, 3);
      for (int i = 0; i < 3; i++) drive(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
      idle(5);

      // reset mid-group discards the partial sum
      for (int i = 0; i < 3; i++) drive(1'b1, 8'd5, 8'd5, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      group(4, 8'd2, 8'd3, 24);
      idle(5);

      for (int i = 0; i < 600; i++) begin
         r  = int'($urandom_range(0, 99));
         ra = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         drive(r < 70, ra, rb, (r >= 95 && r < 99), r == 99);
      end
      idle(6);
      done = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
